axis_to_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/axis_to_uart_tx.sv | 147 ++++++++++++++
 tb/tb_axis_to_uart_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmit and receive paths.
// Holds the frame FSM state encoding, parity modes and baud divider math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Round to the nearest whole clock count per line bit.
  function automatic int calc_baud_div(input int clk_mhz,
                                       input int bit_rate);
    return (clk_mhz * 1000000 + bit_rate / 2) / bit_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..BAUD_DIV-1, tick marks each bit's last cycle.
// Ports: aclk, aresetn (sync, active low), restart (zero count), tick.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic restart,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          last;

  assign last = (cnt_q == CW'(BAUD_DIV - 1));
  assign tick = last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (restart || last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axis_to_uart_tx.sv
// AXI-Stream to UART transmitter: start, LSB-first data, parity, stop.
// Ports: aclk, aresetn, tdata/tvalid/tready sink, TX line, busy.
module axis_to_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50,
  parameter int BIT_RATE      = 115200,
  parameter int BIT_PER_WORD  = 8,
  parameter int PARITY_BIT    = 0,
  parameter int STOP_BITS_NUM = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [BIT_PER_WORD-1:0] tdata,
  input  logic                    tvalid,
  output logic                    tready,
  output logic                    TX,
  output logic                    busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BIT_RATE);
  localparam bit HAS_PAR  = (PARITY_BIT != PARITY_NONE);
  localparam bit ODD_PAR  = (PARITY_BIT == PARITY_ODD);

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("axis_to_uart_tx: BAUD_DIV must be at least 2");
  end
  if (BIT_PER_WORD < 5 || BIT_PER_WORD > 9) begin : g_bad_width
    $error("axis_to_uart_tx: BIT_PER_WORD must be 5..9");
  end
  if (STOP_BITS_NUM < 1 || STOP_BITS_NUM > 2) begin : g_bad_stop
    $error("axis_to_uart_tx: STOP_BITS_NUM must be 1..2");
  end
  if (PARITY_BIT < 0 || PARITY_BIT > 2) begin : g_bad_par
    $error("axis_to_uart_tx: PARITY_BIT must be 0..2");
  end

  uart_state_e             st_q, st_n;
  logic [BIT_PER_WORD-1:0] shift_q, shift_n;
  logic [3:0]              bcnt_q, bcnt_n;
  logic                    par_q, par_n;
  logic                    tx_q, tx_n;
  logic                    rdy_en_q;
  logic                    tick;
  logic                    hs;
  logic                    last_stop;

  uart_baud_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .aclk   (aclk),
    .aresetn(aresetn),
    .restart(hs),
    .tick   (tick)
  );

  assign last_stop = (st_q == ST_STOP) && tick &&
                     (bcnt_q == 4'(STOP_BITS_NUM - 1));

  // rdy_en_q holds tready low for the first cycle out of reset.
  assign tready = rdy_en_q && ((st_q == ST_IDLE) || last_stop);
  assign hs     = tvalid && tready;
  assign busy   = (st_q != ST_IDLE);
  assign TX     = tx_q;

  always_comb begin
    st_n    = st_q;
    shift_n = shift_q;
    bcnt_n  = bcnt_q;
    par_n   = par_q;
    unique case (st_q)
      ST_IDLE: begin
      end
      ST_START: begin
        if (tick) begin
          st_n   = ST_DATA;
          bcnt_n = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bcnt_q == 4'(BIT_PER_WORD - 1)) begin
            st_n   = HAS_PAR ? ST_PARITY : ST_STOP;
            bcnt_n = '0;
          end else begin
            shift_n = shift_q >> 1;
            bcnt_n  = bcnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          st_n   = ST_STOP;
          bcnt_n = '0;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          st_n = ST_IDLE;
        end else if (tick) begin
          bcnt_n = bcnt_q + 4'd1;
        end
      end
      default: st_n = ST_IDLE;
    endcase
    // A handshake (idle or final stop cycle) starts the next frame.
    if (hs) begin
      st_n    = ST_START;
      shift_n = tdata;
      par_n   = (^tdata) ^ ODD_PAR;
      bcnt_n  = '0;
    end
  end

  // TX is registered from the next-state view so it moves
  // on the same edge as the state change.
  always_comb begin
    tx_n = 1'b1;
    unique case (st_n)
      ST_IDLE:   tx_n = 1'b1;
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_n;
      ST_STOP:   tx_n = 1'b1;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      st_q     <= ST_IDLE;
      shift_q  <= '0;
      bcnt_q   <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      st_q     <= st_n;
      shift_q  <= shift_n;
      bcnt_q   <= bcnt_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Self-checking bench for axis_to_uart_tx across several frame formats.
// Instances: 8N1, 7E1, 7O1, 8N2 at BAUD_DIV=10, and defaults at 50 MHz.
module tb_axis_to_uart_tx;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       aresetn;
  logic [7:0] td8;
  logic [6:0] td7;
  logic [4:0] tv;
  logic [4:0] txl;
  logic [4:0] rdy;
  logic [4:0] bsy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  axis_to_uart_tx #(
    .CLK_FREQ(1), .BIT_RATE(100000), .BIT_PER_WORD(8),
    .PARITY_BIT(0), .STOP_BITS_NUM(1)
  ) u0 (
    .aclk(clk), .aresetn(aresetn), .tdata(td8), .tvalid(tv[0]),
    .tready(rdy[0]), .TX(txl[0]), .busy(bsy[0])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(1), .BIT_RATE(100000), .BIT_PER_WORD(7),
    .PARITY_BIT(1), .STOP_BITS_NUM(1)
  ) u1 (
    .aclk(clk), .aresetn(aresetn), .tdata(td7), .tvalid(tv[1]),
    .tready(rdy[1]), .TX(txl[1]), .busy(bsy[1])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(1), .BIT_RATE(100000), .BIT_PER_WORD(7),
    .PARITY_BIT(2), .STOP_BITS_NUM(1)
  ) u2 (
    .aclk(clk), .aresetn(aresetn), .tdata(td7), .tvalid(tv[2]),
    .tready(rdy[2]), .TX(txl[2]), .busy(bsy[2])
  );

  axis_to_uart_tx #(
    .CLK_FREQ(1), .BIT_RATE(100000), .BIT_PER_WORD(8),
    .PARITY_BIT(0), .STOP_BITS_NUM(2)
  ) u3 (
    .aclk(clk), .aresetn(aresetn), .tdata(td8), .tvalid(tv[3]),
    .tready(rdy[3]), .TX(txl[3]), .busy(bsy[3])
  );

  axis_to_uart_tx u4 (
    .aclk(clk), .aresetn(aresetn), .tdata(td8), .tvalid(tv[4]),
    .tready(rdy[4]), .TX(txl[4]), .busy(bsy[4])
  );

  typedef struct {
    int          idx;
    logic [7:0]  data;
    int          nb;
    logic [15:0] seq;
    bit          disturb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Sends one frame and checks TX bit by bit, tready and busy per cycle.
  task automatic run_frame(input int id, input int idx,
                           input logic [7:0] data, input int nb,
                           input logic [15:0] seq, input bit disturb);
    int L;
    int k;
    int bad;
    int rdy_bad;
    int bsy_bad;
    int w;
    L = nb * DIV;
    rdy_bad = 0;
    bsy_bad = 0;
    @(negedge clk);
    td8 = data;
    td7 = data[6:0];
    tv[idx] = 1'b1;
    w = 0;
    while (!rdy[idx] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d_ready_idle", id), int'(rdy[idx]), 1);
    @(negedge clk);
    tv[idx] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        k = b * DIV + c + 1;
        if (disturb) begin
          td8 = ~data;
          td7 = ~data[6:0];
          tv[idx] = (k < L - 2) ? k[0] : 1'b0;
        end
        if (txl[idx] !== seq[b]) bad++;
        if (rdy[idx] !== (k == L)) rdy_bad++;
        if (bsy[idx] !== 1'b1) bsy_bad++;
        @(negedge clk);
      end
      chk($sformatf("v%0d_bit%0d_wrong_cycles", id, b), bad, 0);
    end
    chk($sformatf("v%0d_tready_wrong_cycles", id), rdy_bad, 0);
    chk($sformatf("v%0d_busy_wrong_cycles", id), bsy_bad, 0);
    chk($sformatf("v%0d_busy_after", id), int'(bsy[idx]), 0);
    chk($sformatf("v%0d_tx_after", id), int'(txl[idx]), 1);
  endtask

  task automatic back_to_back();
    logic [19:0] seq;
    int hs;
    int bad;
    int bsy_bad;
    int k;
    seq = {10'b1_00001111_0, 10'b1_01010101_0};
    hs = 0;
    bsy_bad = 0;
    @(negedge clk);
    td8 = 8'h55;
    tv[0] = 1'b1;
    if (rdy[0] && tv[0]) hs++;
    @(negedge clk);
    td8 = 8'h0F;
    for (int b = 0; b < 20; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        k = b * DIV + c + 1;
        if (k == 101) tv[0] = 1'b0;
        if (rdy[0] && tv[0]) hs++;
        if (txl[0] !== seq[b]) bad++;
        if (bsy[0] !== 1'b1) bsy_bad++;
        @(negedge clk);
      end
      chk($sformatf("b2b_bit%0d_wrong_cycles", b), bad, 0);
    end
    chk("b2b_handshakes", hs, 2);
    chk("b2b_busy_wrong_cycles", bsy_bad, 0);
    chk("b2b_busy_after", int'(bsy[0]), 0);
  endtask

  task automatic reset_mid_frame();
    int bad;
    @(negedge clk);
    td8 = 8'h00;
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    repeat (34) @(negedge clk);
    chk("rst_tx_low_before", int'(txl[0]), 0);
    aresetn = 1'b0;
    @(negedge clk);
    chk("rst_tx", int'(txl[0]), 1);
    chk("rst_tready", int'(rdy[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_tready_release", int'(rdy[0]), 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("rst_residual_cycles", bad, 0);
  endtask

  task automatic default_rate();
    int n;
    @(negedge clk);
    td8 = 8'h0F;
    tv[4] = 1'b1;
    @(negedge clk);
    tv[4] = 1'b0;
    n = 0;
    while (txl[4] === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("def_start_bit_cycles", n, 434);
    n = 0;
    while (txl[4] === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("def_four_ones_cycles", n, 1736);
    n = 0;
    while (!rdy[4] && n < 10000) begin
      n++;
      @(negedge clk);
    end
    chk("def_frame_end", int'(rdy[4]), 1);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    aresetn = 1'b0;
    tv = '0;
    td8 = '0;
    td7 = '0;

    vecs[0] = '{0, 8'hA5, 10, {6'b0, 10'b1_10100101_0}, 1'b0};
    vecs[1] = '{1, 8'h07, 10, {6'b0, 10'b1_1_0000111_0}, 1'b0};
    vecs[2] = '{2, 8'h07, 10, {6'b0, 10'b1_0_0000111_0}, 1'b0};
    vecs[3] = '{3, 8'hFF, 11, {5'b0, 11'b11_11111111_0}, 1'b0};
    vecs[4] = '{0, 8'h3C, 10, {6'b0, 10'b1_00111100_0}, 1'b1};
    vecs[5] = '{0, 8'h00, 10, {6'b0, 10'b1_00000000_0}, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_tx", int'(txl), 31);
    chk("reset_tready", int'(rdy), 0);
    chk("reset_busy", int'(bsy), 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("release_tready", int'(rdy), 31);

    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (txl !== 5'h1F || bsy !== 5'h00) bad++;
      @(negedge clk);
    end
    chk("idle_line_cycles", bad, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(i, vecs[i].idx, vecs[i].data, vecs[i].nb,
                vecs[i].seq, vecs[i].disturb);
    end

    back_to_back();
    reset_mid_frame();
    default_rate();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
